// File: rtl/ysyx_23060208_trap_ctrl.sv
// ysyx_23060208_trap_ctrl: sequences ecall/mret through the CSR file
// (mepc, mcause, mstatus, mtvec) and then redirects IFU to the trap target.
// Optional feature macro: TRAP_CTRL_MTVEC_VECTORED_EN -- when defined,
// interrupts with mtvec.MODE==01 jump to base + 4*cause.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload stable until that edge;
// the consumer may raise or drop ready freely. Here req_ready is high only in
// IDLE, and redir_valid/redir_pc are held until redir_ready is seen.
module ysyx_23060208_trap_ctrl #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] CAUSE_ECALL_M = DATA_WIDTH'(11)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [DATA_WIDTH-1:0] req_cause,
  output logic [11:0]           csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [11:0]           csr_waddr2,
  output logic [DATA_WIDTH-1:0] csr_wdata2,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [DATA_WIDTH-1:0] redir_pc,
  output logic                  busy,
  output logic                  err
);

  // 12'h000 is the "no CSR" address driven whenever a port is idle.
  localparam logic [11:0] CSR_NONE    = 12'h000;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, E_EPC, E_STAT, E_TVEC, M_STAT, M_EPC, REDIR
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, target_q, target_d;
  logic                  err_q;
  logic                  accept, illegal;
  logic [DATA_WIDTH-1:0] tvec_base, tvec_target;

  // mtvec.MODE bits are never part of the base address.
  assign tvec_base = {csr_rdata[DATA_WIDTH-1:2], 2'b00};

`ifdef TRAP_CTRL_MTVEC_VECTORED_EN
  // Vectored mode: interrupts land at base + 4*cause (interrupt bit dropped).
  assign tvec_target = (csr_rdata[1:0] == 2'b01 && cause_q[DATA_WIDTH-1])
                     ? tvec_base + {cause_q[DATA_WIDTH-3:0], 2'b00}
                     : tvec_base;
`else
  assign tvec_target = tvec_base;
`endif

  assign busy = (state_q != IDLE);
  assign err  = err_q;

  // State register; async reset drops any trap or redirect in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latched request fields, redirect target and the registered err pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= req_pc;
        cause_q <= (req_cause == '0) ? CAUSE_ECALL_M : req_cause;
      end
      target_q <= target_d;
      err_q    <= illegal;
    end
  end

  // Next-state and per-state CSR port / redirect drive.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    accept      = 1'b0;
    illegal     = 1'b0;
    req_ready   = 1'b0;
    csr_raddr   = CSR_NONE;
    csr_waddr   = CSR_NONE;
    csr_wdata   = '0;
    csr_waddr2  = CSR_NONE;
    csr_wdata2  = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          case (req_type)
            2'b01:   state_d = E_EPC;
            2'b10:   state_d = M_STAT;
            default: illegal = 1'b1;
          endcase
        end
      end
      E_EPC: begin
        csr_waddr  = CSR_MEPC;
        csr_wdata  = pc_q;
        csr_waddr2 = CSR_MCAUSE;
        csr_wdata2 = cause_q;
        state_d    = E_STAT;
      end
      E_STAT: begin
        // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
        csr_raddr       = CSR_MSTATUS;
        csr_waddr       = CSR_MSTATUS;
        csr_wdata       = csr_rdata;
        csr_wdata[7]    = csr_rdata[3];
        csr_wdata[3]    = 1'b0;
        csr_wdata[12:11] = 2'b11;
        state_d         = E_TVEC;
      end
      E_TVEC: begin
        csr_raddr = CSR_MTVEC;
        target_d  = tvec_target;
        state_d   = REDIR;
      end
      M_STAT: begin
        // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M.
        csr_raddr       = CSR_MSTATUS;
        csr_waddr       = CSR_MSTATUS;
        csr_wdata       = csr_rdata;
        csr_wdata[3]    = csr_rdata[7];
        csr_wdata[7]    = 1'b1;
        csr_wdata[12:11] = 2'b11;
        state_d         = M_EPC;
      end
      M_EPC: begin
        csr_raddr = CSR_MEPC;
        target_d  = csr_rdata;
        state_d   = REDIR;
      end
      REDIR: begin
        redir_valid = 1'b1;
        redir_pc    = target_q;
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_trap_ctrl.sv
// Testbench for ysyx_23060208_trap_ctrl: directed scenarios plus randomized
// ecall/mret/illegal traffic against a CSR-level reference model.
// Honors TRAP_CTRL_MTVEC_VECTORED_EN for the expected trap target.
module tb_ysyx_23060208_trap_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_type = 2'b00;
  logic [DW-1:0] req_pc = '0;
  logic [DW-1:0] req_cause = '0;
  logic [11:0]   csr_raddr, csr_waddr, csr_waddr2;
  logic [DW-1:0] csr_rdata, csr_wdata, csr_wdata2;
  logic          redir_valid;
  logic          redir_ready = 1'b0;
  logic [DW-1:0] redir_pc;
  logic          busy, err;

  int checks = 0;
  int errors = 0;
  int bad_writes = 0;

  // Environment CSR file and its backdoor loader.
  logic [DW-1:0] m_status = '0, m_tvec = '0, m_epc = '0, m_cause = '0;
  logic          bd_load = 1'b0;
  logic [DW-1:0] bd_status = '0, bd_tvec = '0, bd_epc = '0, bd_cause = '0;

  logic [DW-1:0] exp_q[$];

  ysyx_23060208_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_pc(req_pc), .req_cause(req_cause),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .busy(busy), .err(err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // CSR file: combinational reads, writes commit at the rising edge.
  always_comb begin
    case (csr_raddr)
      12'h300: csr_rdata = m_status;
      12'h305: csr_rdata = m_tvec;
      12'h341: csr_rdata = m_epc;
      12'h342: csr_rdata = m_cause;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bd_load) begin
      m_status <= bd_status;
      m_tvec   <= bd_tvec;
      m_epc    <= bd_epc;
      m_cause  <= bd_cause;
    end else begin
      if (csr_waddr == 12'h300)      m_status <= csr_wdata;
      else if (csr_waddr == 12'h341) m_epc <= csr_wdata;
      else if (csr_waddr != 12'h000) bad_writes <= bad_writes + 1;
      if (csr_waddr2 == 12'h342)     m_cause <= csr_wdata2;
      else if (csr_waddr2 != 12'h000) bad_writes <= bad_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_csrs(input logic [DW-1:0] st, input logic [DW-1:0] tv,
                           input logic [DW-1:0] ep, input logic [DW-1:0] ca);
    bd_status = st; bd_tvec = tv; bd_epc = ep; bd_cause = ca;
    bd_load = 1'b1;
    @(negedge clk);
    bd_load = 1'b0;
  endtask

  // Driver + reference model for one ecall (01) or mret (10); called at a
  // falling edge with the DUT idle. hold = cycles redir_ready is kept low.
  task automatic run_trap(input logic [1:0] t, input logic [DW-1:0] pc,
                          input logic [DW-1:0] cause, input int hold,
                          output logic [DW-1:0] got_pc);
    logic [DW-1:0] cause_eff, exp_status, exp_tgt, old_status, old_epc, old_cause, old_tvec;
    int lat, exp_lat;
    cause_eff  = (cause == '0) ? 32'd11 : cause;
    old_status = m_status; old_epc = m_epc; old_cause = m_cause; old_tvec = m_tvec;
    if (t == 2'b01) begin
      exp_tgt = old_tvec & ~32'h3;
`ifdef TRAP_CTRL_MTVEC_VECTORED_EN
      if (old_tvec[1:0] == 2'b01 && cause_eff[31])
        exp_tgt = exp_tgt + (cause_eff & 32'h7fff_ffff) * 32'd4;
`endif
      exp_status = (old_status & ~32'h1888) | 32'h1800 | (old_status[3] ? 32'h80 : 32'h0);
      exp_lat = 4;
    end else begin
      exp_tgt = old_epc;
      exp_status = (old_status & ~32'h1888) | 32'h1880 | (old_status[7] ? 32'h8 : 32'h0);
      exp_lat = 3;
    end
    exp_q.push_back(exp_tgt);
    got_pc = '0;

    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = t; req_pc = pc; req_cause = cause;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (redir_valid) begin lat = k; break; end
      check("busy_noready", 32'({busy, req_ready}), 32'd2);
      check("no_err", 32'(err), 32'd0);
      req_valid   = 1'($urandom_range(0, 1));
      req_type    = 2'($urandom_range(0, 3));
      redir_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    if (lat == 0) begin
      void'(exp_q.pop_front());
      return;
    end
    got_pc = redir_pc;
    check("redir_pc", redir_pc, exp_q.pop_front());
    redir_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_type  = 2'b01;
      @(negedge clk);
      check("hold_valid", 32'({redir_valid, req_ready}), 32'd2);
      check("hold_pc", redir_pc, exp_tgt);
    end
    req_valid = 1'b0;
    redir_ready = 1'b1;
    @(negedge clk);
    check("done_idle", 32'({redir_valid, busy, req_ready}), 32'd1);
    redir_ready = 1'($urandom_range(0, 1));
    check("mstatus", m_status, exp_status);
    check("mtvec_kept", m_tvec, old_tvec);
    if (t == 2'b01) begin
      check("mepc", m_epc, pc);
      check("mcause", m_cause, cause_eff);
    end else begin
      check("mepc_kept", m_epc, old_epc);
      check("mcause_kept", m_cause, old_cause);
    end
  endtask

  // Illegal request type: one-cycle err, no CSR activity, still ready.
  task automatic run_illegal(input logic [1:0] t);
    logic [DW-1:0] old_status, old_epc, old_cause;
    old_status = m_status; old_epc = m_epc; old_cause = m_cause;
    req_valid = 1'b1; req_type = t; req_pc = $urandom; req_cause = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("ill_ready", 32'({busy, req_ready}), 32'd1);
    check("ill_addr", 32'(csr_raddr | csr_waddr | csr_waddr2), 32'd0);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("ill_addr2", 32'(csr_raddr | csr_waddr | csr_waddr2), 32'd0);
    check("ill_csr", m_status ^ old_status ^ m_epc ^ old_epc ^ m_cause ^ old_cause, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({req_ready, busy, err, redir_valid}), 32'd8);
    check({tag, "_addr"}, 32'(csr_raddr | csr_waddr | csr_waddr2), 32'd0);
    check({tag, "_data"}, csr_wdata | csr_wdata2 | redir_pc, 32'd0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got, st_before;
    int kind;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed ecall
    load_csrs(32'h0000_0008, 32'h8000_0200, 32'h0, 32'h0);
    run_trap(2'b01, 32'h8000_0100, 32'h0, 0, got);
    check("d_ecall_pc", got, 32'h8000_0200);
    check("d_ecall_mstatus", m_status, 32'h0000_1880);
    check("d_ecall_mcause", m_cause, 32'd11);
    check("d_ecall_mepc", m_epc, 32'h8000_0100);

    // Directed mret with handler-updated mepc
    load_csrs(m_status, m_tvec, 32'h8000_0104, m_cause);
    run_trap(2'b10, 32'h8000_0200, 32'h0, 0, got);
    check("d_mret_pc", got, 32'h8000_0104);
    check("d_mret_mstatus", m_status, 32'h0000_1888);

    // Redirect back-pressure
    run_trap(2'b01, 32'h8000_0300, 32'h0, 5, got);

    // Illegal types
    run_illegal(2'b11);
    run_illegal(2'b00);

    // Async reset in E_STAT
    st_before = m_status;
    req_valid = 1'b1; req_type = 2'b01; req_pc = 32'h8000_0400; req_cause = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_stat", 32'(csr_raddr), 32'h300);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    check("reset_no_stat_write", m_status, st_before);
    rst = 1'b1;
    @(negedge clk);
    run_trap(2'b01, 32'h8000_0500, 32'h0, 1, got);

    // Vectored mtvec with interrupt cause
    load_csrs(32'h0000_0008, 32'h8000_0201, m_epc, m_cause);
    run_trap(2'b01, 32'h8000_0600, 32'h8000_0007, 0, got);
`ifdef TRAP_CTRL_MTVEC_VECTORED_EN
    check("d_vec_pc", got, 32'h8000_021C);
`else
    check("d_vec_pc", got, 32'h8000_0200);
`endif

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        load_csrs($urandom, $urandom, $urandom, $urandom);
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        run_illegal((kind == 0) ? 2'b00 : 2'b11);
      end else begin
        run_trap((kind < 6) ? 2'b01 : 2'b10, $urandom & ~32'h3,
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                 $urandom_range(0, 3), got);
      end
    end

    check("bad_csr_writes", 32'(bad_writes), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_trap_ctrl.md
Name: ysyx_23060208_trap_ctrl

Overview:
Multi-cycle trap sequencer between EXU, the CSR file and IFU. It takes one ecall or mret request per handshake. It sequences the CSR file's read and write ports (mepc, mcause, mstatus, mtvec) in a fixed order and then issues a PC redirect to IFU. It is the only driver of the CSR write ports while a trap or return is in progress.

Parameters:
DATA_WIDTH, 32, CSR/PC data width
CAUSE_ECALL_M, 32'd11, mcause value written for ecall

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  EXU trap request valid
req_ready  out  1  block can accept request
req_type  in  2  01=ecall, 10=mret, 00/11 illegal
req_pc  in  DATA_WIDTH  PC of trapping instruction
req_cause  in  DATA_WIDTH  cause; bit31=interrupt; used only if non-zero, else CAUSE_ECALL_M
csr_raddr  out  12  CSR read address
csr_rdata  in  DATA_WIDTH  CSR read data, combinational from csr_raddr
csr_waddr  out  12  CSR write port 1 address
csr_wdata  out  DATA_WIDTH  CSR write port 1 data
csr_waddr2  out  12  CSR write port 2 address (mcause only)
csr_wdata2  out  DATA_WIDTH  CSR write port 2 data
redir_valid  out  1  redirect valid to IFU
redir_ready  in  1  IFU accepts redirect
redir_pc  out  DATA_WIDTH  redirect target
busy  out  1  state != IDLE
err  out  1  one-cycle pulse on illegal req_type

Behaviour:
- Idle CSR address value is 12'h000 on all CSR address outputs; it matches no CSR.
- Reset (rst=0, async): state IDLE.
  - All outputs 0 except req_ready=1.
  - Latched pc/cause/target cleared.
  - A redirect in flight is dropped.
- CSR write timing: writes commit at the next rising edge. Reads are same-cycle.
- States: IDLE, E_EPC, E_STAT, E_TVEC, M_STAT, M_EPC, REDIR.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_pc and cause (req_cause, or CAUSE_ECALL_M if req_cause==0).
  - Next state: type 01 -> E_EPC; type 10 -> M_STAT; otherwise err=1 next cycle, stay IDLE.
- E_EPC:
  - csr_waddr=12'h341, csr_wdata=latched pc.
  - csr_waddr2=12'h342, csr_wdata2=latched cause.
  - Next state: E_STAT.
- E_STAT:
  - csr_raddr=12'h300, csr_waddr=12'h300.
  - csr_wdata = csr_rdata with bit7(MPIE)=csr_rdata[3], bit3(MIE)=0, bits12:11(MPP)=2'b11.
  - Next state: E_TVEC.
- E_TVEC:
  - csr_raddr=12'h305.
  - Target = {csr_rdata[DW-1:2],2'b00}, registered.
  - Next state: REDIR.
- M_STAT:
  - csr_raddr=12'h300, csr_waddr=12'h300.
  - csr_wdata = csr_rdata with MIE=csr_rdata[7], MPIE=1, MPP=2'b11.
  - Next state: M_EPC.
- M_EPC:
  - csr_raddr=12'h341.
  - Target = csr_rdata, registered.
  - Next state: REDIR.
- REDIR:
  - redir_valid=1, redir_pc=target; both held stable until redir_ready.
  - On redir_valid&redir_ready -> IDLE, and req_ready=1 in the following cycle.
- Latency:
  - ecall: accept edge to redir_valid = 4 cycles.
  - mret: accept edge to redir_valid = 3 cycles.
  - Minimum back-to-back spacing is 5 cycles for ecall and 4 for mret, with redir_ready tied high.
- req_ready=0 in every state other than IDLE. req_valid is ignored in those states; no queueing.
- redir_ready asserted outside REDIR is ignored.
- Only one CSR write per port per cycle; port 2 is written only in E_EPC.
- busy=1 in every state except IDLE.

Optional Feature:
TRAP_CTRL_MTVEC_VECTORED_EN
- Defined: in E_TVEC, if csr_rdata[1:0]==2'b01 and cause bit31==1, target = {mtvec[DW-1:2],2'b00} + (cause[DW-2:0]<<2), truncated to DATA_WIDTH. Otherwise target = direct base.
- Undefined: mtvec[1:0] is always masked and target is always the base. Cause bit31 has no effect on the target.

Test Plan:
- ecall, pc=0x8000_0100, mtvec=0x8000_0200, mstatus=0x0000_0008 -> mepc=0x8000_0100, mcause=11, mstatus=0x0000_1880, redir_pc=0x8000_0200 on cycle 4.
- mret after the ecall above, mepc=0x8000_0104 -> mstatus=0x0000_1888, redir_pc=0x8000_0104 on cycle 3.
- REDIR with redir_ready low for 5 cycles -> redir_valid/pc held constant; req_valid pulses during this time are not accepted (req_ready=0).
- req_type=2'b11 -> err pulses one cycle, no CSR address leaves 12'h000, req_ready stays 1.
- Async reset asserted in E_STAT -> immediate IDLE, all CSR addresses 12'h000, redir_valid=0; a new ecall afterwards completes normally.
- Macro defined, mtvec=0x8000_0201, cause=0x8000_0007 -> redir_pc=0x8000_021C. Macro undefined, same stimulus -> redir_pc=0x8000_0200.
